// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement of renamed instructions, frees the
// previous physical mapping on commit and flushes everything when a mispredict retires.
module reorder_buffer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned IDX_LEN      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dispatch_valid,
  input  logic [REG_ADDR_LEN-1:0] dispatch_arch_dest,
  input  logic [REG_ADDR_LEN-1:0] dispatch_phys_dest,
  input  logic [REG_ADDR_LEN-1:0] dispatch_phys_dest_old,
  output logic                    dispatch_ready,
  output logic [IDX_LEN-1:0]      dispatch_rob_idx,
  input  logic                    cdb_valid,
  input  logic [IDX_LEN-1:0]      cdb_rob_idx,
  input  logic                    cdb_mispredict,
  output logic                    commit_flag,
  output logic [REG_ADDR_LEN-1:0] commit_arch_dest,
  output logic [REG_ADDR_LEN-1:0] commit_phys_reg,
  output logic                    flush_flag,
  output logic [IDX_LEN:0]        count
);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0]        done_q, done_d;
  logic [DEPTH-1:0]        mispred_q, mispred_d;
  logic [REG_ADDR_LEN-1:0] arch_q [DEPTH];
  logic [REG_ADDR_LEN-1:0] phys_q [DEPTH];
  logic [REG_ADDR_LEN-1:0] old_q  [DEPTH];

  logic [IDX_LEN-1:0] head_q, head_d;
  logic [IDX_LEN-1:0] tail_q, tail_d;
  logic [IDX_LEN:0]   count_q, count_d;
  logic               accept;

  // Outputs depend on registered state only; commit fields read zero when idle.
  always_comb begin
    dispatch_ready   = count_q < (IDX_LEN+1)'(DEPTH);
    dispatch_rob_idx = tail_q;
    count            = count_q;
    commit_flag      = valid_q[head_q] & done_q[head_q];
    flush_flag       = commit_flag & mispred_q[head_q];
    commit_arch_dest = commit_flag ? arch_q[head_q] : '0;
    commit_phys_reg  = commit_flag ? old_q[head_q] : '0;
  end

  assign accept = dispatch_valid & dispatch_ready;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + {{IDX_LEN{1'b0}}, accept} - {{IDX_LEN{1'b0}}, commit_flag};

    if (cdb_valid && valid_q[cdb_rob_idx]) begin
      done_d[cdb_rob_idx]    = 1'b1;
      mispred_d[cdb_rob_idx] = cdb_mispredict;
    end

    if (accept) begin
      valid_d[tail_q]   = 1'b1;
      done_d[tail_q]    = 1'b0;
      mispred_d[tail_q] = 1'b0;
      tail_d            = tail_q + IDX_LEN'(1);
    end

    if (commit_flag) begin
      valid_d[head_q]   = 1'b0;
      done_d[head_q]    = 1'b0;
      mispred_d[head_q] = 1'b0;
      head_d            = head_q + IDX_LEN'(1);
    end

    // A retiring mispredict overrides every other same-cycle update.
    if (flush_flag) begin
      valid_d   = '0;
      done_d    = '0;
      mispred_d = '0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        arch_q[i] <= '0;
        phys_q[i] <= '0;
        old_q[i]  <= '0;
      end
    end else if (accept && !flush_flag) begin
      arch_q[tail_q] <= dispatch_arch_dest;
      phys_q[tail_q] <= dispatch_phys_dest;
      old_q[tail_q]  <= dispatch_phys_dest_old;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a table of per-cycle vectors plus hand sequences
// for back-to-back dispatch/commit with head wrap and asynchronous reset.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dispatch_valid;
  logic [4:0] dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_dest_old;
  logic       dispatch_ready;
  logic [2:0] dispatch_rob_idx;
  logic       cdb_valid;
  logic [2:0] cdb_rob_idx;
  logic       cdb_mispredict;
  logic       commit_flag;
  logic [4:0] commit_arch_dest, commit_phys_reg;
  logic       flush_flag;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(8), .REG_ADDR_LEN(5)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .dispatch_valid         (dispatch_valid),
    .dispatch_arch_dest     (dispatch_arch_dest),
    .dispatch_phys_dest     (dispatch_phys_dest),
    .dispatch_phys_dest_old (dispatch_phys_dest_old),
    .dispatch_ready         (dispatch_ready),
    .dispatch_rob_idx       (dispatch_rob_idx),
    .cdb_valid              (cdb_valid),
    .cdb_rob_idx            (cdb_rob_idx),
    .cdb_mispredict         (cdb_mispredict),
    .commit_flag            (commit_flag),
    .commit_arch_dest       (commit_arch_dest),
    .commit_phys_reg        (commit_phys_reg),
    .flush_flag             (flush_flag),
    .count                  (count)
  );

  // Expected outputs describe the state before the vector's clock edge.
  typedef struct {
    logic       rst;
    logic       dv;
    logic [4:0] a, p, o;
    logic       cv;
    logic [2:0] ci;
    logic       cm;
    logic       e_rdy;
    logic [2:0] e_idx;
    logic [3:0] e_cnt;
    logic       e_cf, e_ff;
    logic [4:0] e_cp, e_ca;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic rst, logic dv, int a, int p, int o, logic cv, int ci,
                             logic cm, logic rdy, int idx, int cnt, logic cf, logic ff,
                             int cp, int ca);
    vec_t r;
    r.rst = rst; r.dv = dv; r.a = 5'(a); r.p = 5'(p); r.o = 5'(o);
    r.cv = cv; r.ci = 3'(ci); r.cm = cm;
    r.e_rdy = rdy; r.e_idx = 3'(idx); r.e_cnt = 4'(cnt);
    r.e_cf = cf; r.e_ff = ff; r.e_cp = 5'(cp); r.e_ca = 5'(ca);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic dv, int a, int p, int o, logic cv, int ci, logic cm);
    dispatch_valid         = dv;
    dispatch_arch_dest     = 5'(a);
    dispatch_phys_dest     = 5'(p);
    dispatch_phys_dest_old = 5'(o);
    cdb_valid              = cv;
    cdb_rob_idx            = 3'(ci);
    cdb_mispredict         = cm;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    reset_n = 1'b0;
    #12;
    chk("reset count", int'(count), 0);
    chk("reset ready", int'(dispatch_ready), 1);
    chk("reset rob_idx", int'(dispatch_rob_idx), 0);
    chk("reset commit_flag", int'(commit_flag), 0);
    chk("reset flush_flag", int'(flush_flag), 0);
    chk("reset commit_phys", int'(commit_phys_reg), 0);
    chk("reset commit_arch", int'(commit_arch_dest), 0);

    // Single dispatch, then out-of-order completion with in-order retirement.
    vq.push_back(v(1, 1, 1, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 2, 2, 1,  0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 3, 3, 2,  0, 0, 0,  1, 2, 2, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,  1, 2, 0,  1, 3, 3, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,  1, 0, 0,  1, 3, 3, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 0,  1, 3, 3, 1, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 0,  1, 3, 2, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,  1, 1, 0,  1, 3, 2, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 0,  1, 3, 2, 1, 0, 1, 2));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 0,  1, 3, 1, 1, 0, 2, 3));
    vq.push_back(v(0, 0, 0, 0, 0,  0, 0, 0,  1, 3, 0, 0, 0, 0, 0));
    // Fill, reject when full (also during commit), then tail wrap.
    vq.push_back(v(1, 1, 0, 8, 16, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i < 8; i++)
      vq.push_back(v(0, 1, i, 8 + i, 16 + i, 0, 0, 0, 1, i, i, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 9, 9, 9,    0, 0, 0,  0, 0, 8, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 9, 9, 9,    1, 0, 0,  0, 0, 8, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 10, 10, 10, 0, 0, 0,  0, 0, 8, 1, 0, 16, 0));
    vq.push_back(v(0, 1, 11, 11, 11, 0, 0, 0,  1, 0, 7, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,    1, 1, 0,  0, 1, 8, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,    0, 0, 0,  0, 1, 8, 1, 0, 17, 1));
    vq.push_back(v(0, 0, 0, 0, 0,    0, 0, 0,  1, 1, 7, 0, 0, 0, 0));
    // Mispredict at idx 1 flushes; same-cycle dispatch and CDB are discarded.
    vq.push_back(v(1, 1, 4, 12, 20, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 5, 13, 21, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 6, 14, 22, 0, 0, 0,  1, 2, 2, 0, 0, 0, 0));
    vq.push_back(v(0, 1, 7, 15, 23, 0, 0, 0,  1, 3, 3, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,   1, 1, 1,  1, 4, 4, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,   1, 0, 0,  1, 4, 4, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,   0, 0, 0,  1, 4, 4, 1, 0, 20, 4));
    vq.push_back(v(0, 1, 9, 9, 9,   1, 2, 0,  1, 4, 3, 1, 1, 21, 5));
    vq.push_back(v(0, 0, 0, 0, 0,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 0,   0, 0, 0,  1, 0, 0, 0, 0, 0, 0));

    foreach (vq[k]) begin
      if (vq[k].rst) do_reset();
      drive(vq[k].dv, int'(vq[k].a), int'(vq[k].p), int'(vq[k].o),
            vq[k].cv, int'(vq[k].ci), vq[k].cm);
      #1;
      chk($sformatf("v%0d ready", k), int'(dispatch_ready), int'(vq[k].e_rdy));
      chk($sformatf("v%0d rob_idx", k), int'(dispatch_rob_idx), int'(vq[k].e_idx));
      chk($sformatf("v%0d count", k), int'(count), int'(vq[k].e_cnt));
      chk($sformatf("v%0d commit_flag", k), int'(commit_flag), int'(vq[k].e_cf));
      chk($sformatf("v%0d flush_flag", k), int'(flush_flag), int'(vq[k].e_ff));
      if (vq[k].e_cf) begin
        chk($sformatf("v%0d commit_phys", k), int'(commit_phys_reg), int'(vq[k].e_cp));
        chk($sformatf("v%0d commit_arch", k), int'(commit_arch_dest), int'(vq[k].e_ca));
      end
      step();
    end

    // Steady state: one dispatch and one commit per cycle, head and tail wrap.
    do_reset();
    drive(1'b1, 1, 1, 0, 1'b0, 0, 1'b0); step();
    drive(1'b1, 2, 2, 1, 1'b0, 0, 1'b0); step();
    drive(1'b1, 3, 3, 2, 1'b1, 0, 1'b0); step();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, k + 4, k + 4, k + 3, 1'b1, (k + 1) % 8, 1'b0);
      #1;
      chk($sformatf("ss%0d count", k), int'(count), 3);
      chk($sformatf("ss%0d commit_flag", k), int'(commit_flag), 1);
      chk($sformatf("ss%0d commit_phys", k), int'(commit_phys_reg), k);
      chk($sformatf("ss%0d commit_arch", k), int'(commit_arch_dest), k + 1);
      chk($sformatf("ss%0d rob_idx", k), int'(dispatch_rob_idx), (k + 3) % 8);
      step();
    end

    // Asynchronous reset mid-cycle with five entries held and the head committing.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i + 1, i + 1, i + 7, (i == 4), 0, 1'b0);
      step();
    end
    drive(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    #1;
    chk("pre-async count", int'(count), 5);
    chk("pre-async commit_flag", int'(commit_flag), 1);
    chk("pre-async commit_phys", int'(commit_phys_reg), 7);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async count", int'(count), 0);
    chk("async commit_flag", int'(commit_flag), 0);
    chk("async commit_phys", int'(commit_phys_reg), 0);
    chk("async commit_arch", int'(commit_arch_dest), 0);
    chk("async ready", int'(dispatch_ready), 1);
    chk("async rob_idx", int'(dispatch_rob_idx), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post-async count", int'(count), 0);
    chk("post-async commit_flag", int'(commit_flag), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
